// File: rtl/skew_tile_sequencer.sv
// Sequences one systolic-array tile: preload N B rows, stream k_len A rows
// with MAC, flush the skew pipes, then issue per-tile accumulator commands
// aligned with deskewed results leaving the array.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, start_ready tile request / accept window (high only in IDLE)
//   clear_accum, k_len tile parameters captured with start
//   a_valid, a_rd     A-operand buffer handshake (pop only with valid)
//   b_valid, b_rd     B-operand buffer handshake (pop only with valid)
//   command_a/_b      PE commands to the A/B input-skew blocks
//   accum_command     accumulator command to the output-deskew block
//   busy, done        activity flag and one-cycle completion pulse
//   stall_count       saturating count of operand-starved cycles this tile
//
// Every output is a register updated on the edge where the FSM evaluates its
// current state, so output cycle n shows the action taken at edge n.
module skew_tile_sequencer #(
    parameter int unsigned ARRAY_DIMENSION     = 8,
    parameter int unsigned PE_COMMAND_WIDTH    = 2,
    parameter int unsigned ACCUM_COMMAND_WIDTH = 2,
    parameter int unsigned K_WIDTH             = 16,
    parameter int unsigned DRAIN_CYCLES        = 2 * ARRAY_DIMENSION + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           clear_accum,
    input  logic [K_WIDTH-1:0]             k_len,
    output logic                           start_ready,
    input  logic                           a_valid,
    output logic                           a_rd,
    input  logic                           b_valid,
    output logic                           b_rd,
    output logic [PE_COMMAND_WIDTH-1:0]    command_a,
    output logic [PE_COMMAND_WIDTH-1:0]    command_b,
    output logic [ACCUM_COMMAND_WIDTH-1:0] accum_command,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    stall_count
);

    // One shared phase counter, wide enough for N, DRAIN_CYCLES and k_len.
    localparam int unsigned LOAD_W  = $clog2(ARRAY_DIMENSION + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned PHASE_W = (LOAD_W > DRAIN_W) ? LOAD_W : DRAIN_W;
    localparam int unsigned CNT_W   = (K_WIDTH > PHASE_W) ? K_WIDTH : PHASE_W;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ARRAY_DIMENSION - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_FIRST  = CNT_W'(DRAIN_CYCLES - ARRAY_DIMENSION);

    localparam logic [PE_COMMAND_WIDTH-1:0] PE_NOP    = PE_COMMAND_WIDTH'(0);
    localparam logic [PE_COMMAND_WIDTH-1:0] PE_LOAD_B = PE_COMMAND_WIDTH'(1);
    localparam logic [PE_COMMAND_WIDTH-1:0] PE_MAC    = PE_COMMAND_WIDTH'(2);
    localparam logic [PE_COMMAND_WIDTH-1:0] PE_DRAIN  = PE_COMMAND_WIDTH'(3);

    localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACC_NOP  = ACCUM_COMMAND_WIDTH'(0);
    localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACC_INIT = ACCUM_COMMAND_WIDTH'(1);
    localparam logic [ACCUM_COMMAND_WIDTH-1:0] ACC_ADD  = ACCUM_COMMAND_WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [K_WIDTH-1:0] k_len_q;
    logic               clear_q;
    logic [K_WIDTH-1:0] k_last;

    // Index of the final A row; only consulted in STREAM, where k_len_q != 0,
    // so the counter never has to reach k_len itself (no wrap at max k_len).
    assign k_last = k_len_q - K_WIDTH'(1);

    // Tile FSM with registered commands/handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            k_len_q       <= '0;
            clear_q       <= 1'b0;
            start_ready   <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            a_rd          <= 1'b0;
            b_rd          <= 1'b0;
            command_a     <= PE_NOP;
            command_b     <= PE_NOP;
            accum_command <= ACC_NOP;
            stall_count   <= '0;
        end else begin
            start_ready   <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            a_rd          <= 1'b0;
            b_rd          <= 1'b0;
            command_a     <= PE_NOP;
            command_b     <= PE_NOP;
            accum_command <= ACC_NOP;

            case (state)
                S_IDLE: begin
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                    if (start) begin
                        k_len_q     <= k_len;
                        clear_q     <= clear_accum;
                        stall_count <= '0;
                        cnt         <= '0;
                        state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (b_valid) begin
                        command_b <= PE_LOAD_B;
                        b_rd      <= 1'b1;
                        if (cnt == LOAD_LAST) begin
                            cnt   <= '0;
                            state <= (k_len_q != '0) ? S_STREAM : S_DRAIN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (stall_count != '1) begin
                        stall_count <= stall_count + 32'd1;
                    end
                end

                S_STREAM: begin
                    if (a_valid) begin
                        command_a <= PE_MAC;
                        a_rd      <= 1'b1;
                        if (cnt == CNT_W'(k_last)) begin
                            cnt   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (stall_count != '1) begin
                        stall_count <= stall_count + 32'd1;
                    end
                end

                S_DRAIN: begin
                    if (cnt == '0) begin
                        command_a <= PE_DRAIN;
                        command_b <= PE_DRAIN;
                    end
                    // Last N drain cycles line up with deskewed result rows.
                    if (cnt >= ACC_FIRST) begin
                        accum_command <= clear_q ? ACC_INIT : ACC_ADD;
                    end
                    if (cnt == DRAIN_LAST) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
